// File: rtl/mealy_1101_if.sv
// rtl/mealy_1101_if.sv - serial bit in / match flag out bundle for the sequence detector
interface mealy_1101_if;
    logic x;
    logic z;

    // Stream source drives bits and observes the match flag.
    modport master (output x, input z);

    // Detector consumes bits and produces the match flag.
    modport slave (input x, output z);
endinterface

// File: rtl/mealy_1101.sv
// rtl/mealy_1101.sv - overlapping serial pattern detector, Mealy FSM with KMP next-state table
module mealy_1101 #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101
) (
    input  logic         clk,
    input  logic         rst,
    mealy_1101_if.slave  bus
);

    // State holds the length of the longest pattern prefix that ends the consumed stream.
    localparam int SW        = (PAT_LEN <= 2) ? 1 : $clog2(PAT_LEN);
    localparam int NUM_CODES = 2 ** SW;
    localparam int TBL_W     = 2 * NUM_CODES * SW;

    typedef logic [SW-1:0] state_t;

    localparam state_t LAST_STATE = state_t'(PAT_LEN - 1);
    localparam logic   LAST_BIT   = PATTERN[0];

    // Pattern bit i counted from the oldest bit (i = 0 is the MSB of PATTERN).
    function automatic logic pat_bit(input int i);
        logic [15:0] shifted;
        shifted = 16'(PATTERN) >> (PAT_LEN - 1 - i);
        return shifted[0];
    endfunction

    // Bit i of the candidate stream: matched prefix of length s followed by the new bit.
    function automatic logic seq_bit(input int s, input logic b, input int i);
        return (i < s) ? pat_bit(i) : b;
    endfunction

    // Next state for every (state, bit) pair: the longest proper prefix that is a suffix
    // of prefix(s) followed by b. A full match therefore lands on the longest border,
    // which gives overlap for free. Codes above PAT_LEN-1 keep a zero entry so an
    // illegal state falls back to state 0 on the next edge.
    function automatic logic [TBL_W-1:0] build_table();
        logic [TBL_W-1:0] tbl;
        logic             ok;
        int               best;
        tbl = '0;
        for (int s = 0; s < PAT_LEN; s++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                for (int k = 1; (k < PAT_LEN) && (k <= s + 1); k++) begin
                    ok = 1'b1;
                    for (int j = 0; j < k; j++) begin
                        if (seq_bit(s, b[0], s + 1 - k + j) != pat_bit(j)) begin
                            ok = 1'b0;
                        end
                    end
                    if (ok) begin
                        best = k;
                    end
                end
                tbl = tbl | (TBL_W'(best) << ((2 * s + b) * SW));
            end
        end
        return tbl;
    endfunction

    localparam logic [TBL_W-1:0] NEXT_TBL = build_table();

    state_t state_q;
    state_t state_d;

    // Look up the next state for the current state and input bit.
    always_comb begin
        state_d = '0;
        state_d = state_t'(NEXT_TBL >> (int'({state_q, bus.x}) * SW));
    end

    // State register; reset clears all match history at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    // Match flag follows x combinationally while the last prefix state is held.
    assign bus.z = ~rst & (state_q == LAST_STATE) & (bus.x == LAST_BIT);

endmodule

// File: tb/tb_mealy_1101.sv
// tb/tb_mealy_1101.sv - self-checking bench for mealy_1101 with sliding-window reference
module tb_mealy_1101;

    localparam int         L = 4;
    localparam logic [3:0] P = 4'b1101;

    logic clk = 1'b0;
    logic rst;

    mealy_1101_if bus_if ();

    mealy_1101 #(.PAT_LEN(L), .PATTERN(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: bits consumed since the last reset, newest in bit 0.
    logic [15:0] hist;
    int          cnt;

    function automatic logic model_z(input logic b);
        logic [15:0] w;
        w = {hist[14:0], b};
        return (cnt >= L - 1) && (w[L-1:0] == P);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_state0(input string tag);
        checks++;
        assert (dut.state_q === 2'd0) else begin
            errors++;
            $error("FAIL %s: observed state %0d expected 0", tag, dut.state_q);
        end
    endtask

    // Entered just after a falling edge: drive x, sample z before the rising edge.
    task automatic step(input string tag, input logic b, input logic use_exp, input logic e);
        logic exp;
        bus_if.x = b;
        #1;
        exp = use_exp ? e : model_z(b);
        check(tag, bus_if.z, exp);
        @(posedge clk);
        hist = {hist[14:0], b};
        cnt++;
        @(negedge clk);
    endtask

    // Short reset pulse between clock edges; effect must be immediate.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check(tag, bus_if.z, 1'b0);
        check_state0(tag);
        rst  = 1'b0;
        hist = '0;
        cnt  = 0;
    endtask

    task automatic run_seq(input string tag, input string bits, input string exps);
        for (int i = 0; i < bits.len(); i++) begin
            step(tag, bits[i] == "1", 1'b1, exps[i] == "1");
        end
    endtask

    initial begin
        rst      = 1'b1;
        bus_if.x = 1'b0;
        hist     = '0;
        cnt      = 0;
        #1;
        check("rst_z_x0", bus_if.z, 1'b0);
        bus_if.x = 1'b1;
        #1;
        check("rst_z_x1", bus_if.z, 1'b0);
        check_state0("rst_state");
        @(negedge clk);
        rst = 1'b0;

        run_seq("to_s3", "110", "000");
        bus_if.x = 1'b1;
        #1;
        check("s3_x1_z", bus_if.z, 1'b1);
        pulse_reset("async_rst");

        run_seq("basic", "1101", "0001");
        pulse_reset("rst_a");
        run_seq("overlap", "11011101001101", "00010001000001");
        pulse_reset("rst_b");
        run_seq("shared", "1101101", "0001001");
        pulse_reset("rst_c");
        run_seq("near_a", "11101", "00001");
        pulse_reset("rst_d");
        run_seq("near_b", "101001100", "000000000");
        pulse_reset("rst_e");
        run_seq("pre", "110", "000");
        pulse_reset("mid_rst");
        run_seq("mid", "11101", "00001");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset("rnd_rst");
            end
            step("rnd", $urandom_range(0, 3) != 0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
